// File: rtl/crc_stream_pipe.sv
// Pipelined per-word CRC generator: each accepted word walks an N-stage chain,
// every stage folding P_BITS_PER_STAGE data bits into the word's own CRC register.
module crc_stream_pipe #(
    parameter int                 P_WIDTH          = 8,
    parameter logic [P_WIDTH-1:0] P_POLYNOM        = P_WIDTH'(8'h31),
    parameter logic [P_WIDTH-1:0] P_INIT           = '0,
    parameter logic [P_WIDTH-1:0] P_XOROUT         = '0,
    parameter int                 P_DATA_W         = 8,
    parameter int                 P_BITS_PER_STAGE = 1,
    parameter int                 P_REFIN          = 0,
    parameter int                 P_REFOUT         = 0,
    parameter int                 P_TAG_W          = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [P_DATA_W-1:0] in_data,
    input  logic [P_TAG_W-1:0]  in_tag,
    input  logic [P_WIDTH-1:0]  in_check,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [P_WIDTH-1:0]  out_crc,
    output logic [P_TAG_W-1:0]  out_tag,
    output logic                out_match,
    output logic                busy
);

    localparam int B = (P_BITS_PER_STAGE < 1) ? 1 : P_BITS_PER_STAGE;
    localparam int N = P_DATA_W / B;

    generate
        if (P_BITS_PER_STAGE < 1 || (P_DATA_W % B) != 0) begin : g_bad_bits_per_stage
            $error("crc_stream_pipe: P_BITS_PER_STAGE must divide P_DATA_W");
        end
        if (P_WIDTH < 1 || P_WIDTH > 32) begin : g_bad_width
            $error("crc_stream_pipe: P_WIDTH must be in 1..32");
        end
    endgenerate

    // Folds B bits into the CRC, the first bit in time sitting at bits[B-1].
    function automatic logic [P_WIDTH-1:0] crc_step(input logic [P_WIDTH-1:0] crc,
                                                    input logic [B-1:0]       bits);
        logic [P_WIDTH-1:0] c;
        logic               fb;
        c = crc;
        for (int j = B - 1; j >= 0; j--) begin
            fb = c[P_WIDTH-1] ^ bits[j];
            c  = (c << 1) ^ (fb ? P_POLYNOM : '0);
        end
        return c;
    endfunction

    function automatic logic [P_DATA_W-1:0] rev_data(input logic [P_DATA_W-1:0] d);
        logic [P_DATA_W-1:0] r;
        for (int i = 0; i < P_DATA_W; i++) r[i] = d[P_DATA_W-1-i];
        return r;
    endfunction

    function automatic logic [P_WIDTH-1:0] rev_crc(input logic [P_WIDTH-1:0] c);
        logic [P_WIDTH-1:0] r;
        for (int i = 0; i < P_WIDTH; i++) r[i] = c[P_WIDTH-1-i];
        return r;
    endfunction

    logic                vld_q  [N];
    logic                vld_d  [N];
    logic [P_WIDTH-1:0]  crc_q  [N];
    logic [P_WIDTH-1:0]  crc_d  [N];
    logic [P_DATA_W-1:0] data_q [N];
    logic [P_DATA_W-1:0] data_d [N];
    logic [P_TAG_W-1:0]  tag_q  [N];
    logic [P_TAG_W-1:0]  tag_d  [N];
    logic [P_WIDTH-1:0]  chk_q  [N];
    logic [P_WIDTH-1:0]  chk_d  [N];

    logic                adv;
    logic [P_DATA_W-1:0] data_ord;
    logic [P_WIDTH-1:0]  fin_crc;

    // Data is normalised to MSB-first once; each stage then eats the top B bits
    // of what it received and passes the remainder on, left-aligned.
    assign data_ord = (P_REFIN != 0) ? rev_data(in_data) : in_data;
    assign adv      = !vld_q[N-1] || out_ready;
    assign in_ready = adv;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            vld_d[k]  = vld_q[k];
            crc_d[k]  = crc_q[k];
            data_d[k] = data_q[k];
            tag_d[k]  = tag_q[k];
            chk_d[k]  = chk_q[k];
        end
        if (adv) begin
            vld_d[0]  = in_valid;
            crc_d[0]  = crc_step(P_INIT, data_ord[P_DATA_W-1 -: B]);
            data_d[0] = data_ord << B;
            tag_d[0]  = in_tag;
            chk_d[0]  = in_check;
            for (int k = 1; k < N; k++) begin
                vld_d[k]  = vld_q[k-1];
                crc_d[k]  = crc_step(crc_q[k-1], data_q[k-1][P_DATA_W-1 -: B]);
                data_d[k] = data_q[k-1] << B;
                tag_d[k]  = tag_q[k-1];
                chk_d[k]  = chk_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                vld_q[k]  <= 1'b0;
                crc_q[k]  <= '0;
                data_q[k] <= '0;
                tag_q[k]  <= '0;
                chk_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                vld_q[k]  <= vld_d[k];
                crc_q[k]  <= crc_d[k];
                data_q[k] <= data_d[k];
                tag_q[k]  <= tag_d[k];
                chk_q[k]  <= chk_d[k];
            end
        end
    end

    // Output stage: reflect/xor, then gate everything to zero when idle.
    assign fin_crc   = ((P_REFOUT != 0) ? rev_crc(crc_q[N-1]) : crc_q[N-1]) ^ P_XOROUT;
    assign out_valid = vld_q[N-1];
    assign out_crc   = out_valid ? fin_crc : '0;
    assign out_tag   = out_valid ? tag_q[N-1] : '0;
    assign out_match = out_valid && (out_crc == chk_q[N-1]);

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < N; k++) busy = busy | vld_q[k];
    end

endmodule

// File: tb/tb_crc_stream_pipe.sv
// Self-checking bench for crc_stream_pipe: directed CRC-8/0x31 cases plus a
// randomized sweep over stage width and reflection against a bit-list model.
module tb_crc_stream_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic rst;

    // Main instance (B=1) and two init/xorout variants sharing its stimulus
    logic       m_valid, m_irdy, m_ordy, m_ovld, m_match, m_busy;
    logic [7:0] m_data, m_check, m_crc;
    logic [3:0] m_tag, m_tago;
    logic       di_irdy, di_ovld, di_match, di_busy;
    logic [7:0] di_crc;
    logic [3:0] di_tago;
    logic       dx_irdy, dx_ovld, dx_match, dx_busy;
    logic [7:0] dx_crc;
    logic [3:0] dx_tago;

    crc_stream_pipe #(.P_WIDTH(8), .P_POLYNOM(8'h31), .P_INIT(8'h00), .P_XOROUT(8'h00),
                      .P_DATA_W(8), .P_BITS_PER_STAGE(1), .P_REFIN(0), .P_REFOUT(0), .P_TAG_W(4))
    dut (.clk(clk), .rst(rst), .in_valid(m_valid), .in_ready(m_irdy), .in_data(m_data),
         .in_tag(m_tag), .in_check(m_check), .out_valid(m_ovld), .out_ready(m_ordy),
         .out_crc(m_crc), .out_tag(m_tago), .out_match(m_match), .busy(m_busy));

    crc_stream_pipe #(.P_WIDTH(8), .P_POLYNOM(8'h31), .P_INIT(8'hFF), .P_XOROUT(8'h00),
                      .P_DATA_W(8), .P_BITS_PER_STAGE(1), .P_REFIN(0), .P_REFOUT(0), .P_TAG_W(4))
    dut_i (.clk(clk), .rst(rst), .in_valid(m_valid), .in_ready(di_irdy), .in_data(m_data),
           .in_tag(m_tag), .in_check(m_check), .out_valid(di_ovld), .out_ready(m_ordy),
           .out_crc(di_crc), .out_tag(di_tago), .out_match(di_match), .busy(di_busy));

    crc_stream_pipe #(.P_WIDTH(8), .P_POLYNOM(8'h31), .P_INIT(8'hFF), .P_XOROUT(8'hFF),
                      .P_DATA_W(8), .P_BITS_PER_STAGE(1), .P_REFIN(0), .P_REFOUT(0), .P_TAG_W(4))
    dut_x (.clk(clk), .rst(rst), .in_valid(m_valid), .in_ready(dx_irdy), .in_data(m_data),
           .in_tag(m_tag), .in_check(m_check), .out_valid(dx_ovld), .out_ready(m_ordy),
           .out_crc(dx_crc), .out_tag(dx_tago), .out_match(dx_match), .busy(dx_busy));

    // Sweep: 16 instances over B in {1,2,4,8} x REFIN x REFOUT
    logic       s_valid;
    logic [7:0] s_data, s_check;
    logic [3:0] s_tag;
    logic       s_ordy  [16];
    logic       s_irdy  [16];
    logic       s_ovld  [16];
    logic       s_match [16];
    logic       s_busy  [16];
    logic [7:0] s_crc   [16];
    logic [3:0] s_tago  [16];

    for (genvar g = 0; g < 16; g++) begin : g_sw
        crc_stream_pipe #(.P_WIDTH(8), .P_POLYNOM(8'h31),
                          .P_INIT(((g % 2) == 1) ? 8'hFF : 8'h00),
                          .P_XOROUT(((g % 3) == 0) ? 8'h5A : 8'h00),
                          .P_DATA_W(8), .P_BITS_PER_STAGE(1 << (g % 4)),
                          .P_REFIN((g / 4) % 2), .P_REFOUT(g / 8), .P_TAG_W(4))
        u (.clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_irdy[g]), .in_data(s_data),
           .in_tag(s_tag), .in_check(s_check), .out_valid(s_ovld[g]), .out_ready(s_ordy[g]),
           .out_crc(s_crc[g]), .out_tag(s_tago[g]), .out_match(s_match[g]), .busy(s_busy[g]));
    end

    function automatic int sw_b(int g);                return 1 << (g % 4);             endfunction
    function automatic bit sw_refin(int g);            return ((g / 4) % 2) == 1;       endfunction
    function automatic bit sw_refout(int g);           return (g / 8) == 1;             endfunction
    function automatic logic [7:0] sw_init(int g);     return ((g % 2) == 1) ? 8'hFF : 8'h00; endfunction
    function automatic logic [7:0] sw_xor(int g);      return ((g % 3) == 0) ? 8'h5A : 8'h00; endfunction

    // Reference: list the message bits in transmission order, then run the
    // textbook shift-register division over that list.
    function automatic logic [7:0] ref_crc(input logic [7:0] d, input bit refin, input bit refout,
                                           input logic [7:0] init, input logic [7:0] xorout);
        bit         msg [8];
        logic [7:0] c;
        logic [7:0] r;
        for (int i = 0; i < 8; i++) msg[i] = refin ? d[i] : d[7-i];
        c = init;
        foreach (msg[i]) begin
            if (c[7] ^ msg[i]) c = {c[6:0], 1'b0} ^ 8'h31;
            else               c = {c[6:0], 1'b0};
        end
        for (int i = 0; i < 8; i++) r[i] = c[7-i];
        return (refout ? r : c) ^ xorout;
    endfunction

    function automatic logic [7:0] sw_ref(input logic [7:0] d, input int g);
        return ref_crc(d, sw_refin(g), sw_refout(g), sw_init(g), sw_xor(g));
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (m_ovld !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got %b exp 0", m_ovld); end
        checks++; if (m_crc !== 8'h00)  begin errors++; $display("FAIL reset_out_crc got %h exp 00", m_crc); end
        checks++; if (m_tago !== 4'h0)  begin errors++; $display("FAIL reset_out_tag got %h exp 0", m_tago); end
        checks++; if (m_match !== 1'b0) begin errors++; $display("FAIL reset_out_match got %b exp 0", m_match); end
        checks++; if (m_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b exp 0", m_busy); end
        checks++; if (m_irdy !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b exp 1", m_irdy); end
    endtask

    task automatic test_basic();
        int lat;
        lat = 0;
        m_ordy = 1'b1; m_valid = 1'b1; m_data = 8'h30; m_tag = 4'h5; m_check = 8'hC5;
        #1;
        checks++; if (m_irdy !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %b exp 1", m_irdy); end
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(posedge clk);
            #1;
            m_valid = 1'b0;
            #1;
            if (m_ovld === 1'b1) begin
                lat = c;
                checks++; if (m_crc !== 8'hC5) begin errors++; $display("FAIL basic_crc got %h exp c5", m_crc); end
                checks++; if (m_tago !== 4'h5) begin errors++; $display("FAIL basic_tag got %h exp 5", m_tago); end
                checks++; if (m_match !== 1'b1) begin errors++; $display("FAIL basic_match got %b exp 1", m_match); end
            end
        end
        checks++; if (lat != 8) begin errors++; $display("FAIL basic_latency got %0d exp 8", lat); end
        @(posedge clk);
        #2;
        checks++; if (m_ovld !== 1'b0 || m_busy !== 1'b0)
            begin errors++; $display("FAIL basic_drain got valid=%b busy=%b exp 0 0", m_ovld, m_busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3] = '{8'h01, 8'h00, 8'h30};
        logic [7:0] exp_c [3] = '{8'h31, 8'h00, 8'hC5};
        logic       exp_m [3] = '{1'b0, 1'b1, 1'b0};
        int n;
        int prev;
        n = 0; prev = -1;
        m_ordy = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c < 3) begin
                m_valid = 1'b1; m_data = words[c]; m_tag = 4'(c + 1); m_check = 8'h00;
            end else begin
                m_valid = 1'b0;
            end
            #1;
            if (m_ovld === 1'b1) begin
                if (n < 3) begin
                    checks++; if (m_crc !== exp_c[n])
                        begin errors++; $display("FAIL b2b_crc[%0d] got %h exp %h", n, m_crc, exp_c[n]); end
                    checks++; if (m_match !== exp_m[n])
                        begin errors++; $display("FAIL b2b_match[%0d] got %b exp %b", n, m_match, exp_m[n]); end
                    checks++; if (m_tago !== 4'(n + 1))
                        begin errors++; $display("FAIL b2b_tag[%0d] got %h exp %h", n, m_tago, 4'(n + 1)); end
                    if (n > 0) begin
                        checks++; if (c != prev + 1)
                            begin errors++; $display("FAIL b2b_gap[%0d] got cycle %0d exp %0d", n, c, prev + 1); end
                    end
                end
                prev = c;
                n++;
            end
            @(posedge clk);
            #1;
        end
        checks++; if (n != 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", n); end
    endtask

    task automatic test_init();
        bit seen;
        seen = 1'b0;
        m_ordy = 1'b1; m_valid = 1'b1; m_data = 8'h30; m_tag = 4'h3; m_check = 8'h69;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(posedge clk);
            #1;
            m_valid = 1'b0;
            #1;
            if (di_ovld === 1'b1) begin
                seen = 1'b1;
                checks++; if (di_crc !== 8'h69) begin errors++; $display("FAIL init_ff_crc got %h exp 69", di_crc); end
                checks++; if (di_match !== 1'b1) begin errors++; $display("FAIL init_ff_match got %b exp 1", di_match); end
                checks++; if (dx_crc !== 8'h96) begin errors++; $display("FAIL init_ff_xor_crc got %h exp 96", dx_crc); end
                checks++; if (dx_ovld !== 1'b1) begin errors++; $display("FAIL init_ff_xor_valid got %b exp 1", dx_ovld); end
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL init_timeout got no out_valid exp out_valid"); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        logic [7:0] wd  [10];
        logic [7:0] wc  [10];
        logic [7:0] ex  [10];
        int  sent, rcvd, hold;
        bit  stalled;
        logic [7:0] stall_crc;
        bit  ret;
        sent = 0; rcvd = 0; hold = 0; stalled = 1'b0; stall_crc = 8'h00;
        for (int i = 0; i < 10; i++) begin
            wd[i] = 8'($urandom);
            ex[i] = ref_crc(wd[i], 1'b0, 1'b0, 8'h00, 8'h00);
            wc[i] = (i % 3 == 0) ? ex[i] : 8'($urandom);
        end
        for (int c = 0; c < 200 && rcvd < 10; c++) begin
            if (!stalled && m_ovld === 1'b1) begin
                stalled = 1'b1; hold = 5; stall_crc = m_crc;
            end
            m_ordy  = (hold > 0) ? 1'b0 : 1'b1;
            m_valid = (sent < 10);
            if (sent < 10) begin m_data = wd[sent]; m_tag = 4'(sent); m_check = wc[sent]; end
            #1;
            if (hold > 0) begin
                checks++; if (m_irdy !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b exp 0", m_irdy); end
                checks++; if (m_crc !== stall_crc || m_ovld !== 1'b1)
                    begin errors++; $display("FAIL stall_hold got crc=%h valid=%b exp crc=%h valid=1", m_crc, m_ovld, stall_crc); end
                hold--;
            end
            ret = (m_ovld === 1'b1) && m_ordy;
            if (ret) begin
                checks++; if (m_crc !== ex[rcvd] || m_tago !== 4'(rcvd) || m_match !== (ex[rcvd] == wc[rcvd]))
                    begin errors++; $display("FAIL stall_result[%0d] got crc=%h tag=%h m=%b exp crc=%h tag=%h m=%b",
                          rcvd, m_crc, m_tago, m_match, ex[rcvd], 4'(rcvd), ex[rcvd] == wc[rcvd]); end
                if (rcvd == 9) begin
                    checks++; if (m_busy !== 1'b1) begin errors++; $display("FAIL stall_busy_last got %b exp 1", m_busy); end
                end
                rcvd++;
            end
            if (m_valid && m_irdy === 1'b1) sent++;
            @(posedge clk);
            #1;
        end
        m_valid = 1'b0;
        m_ordy = 1'b1;
        #1;
        checks++; if (rcvd != 10) begin errors++; $display("FAIL stall_count got %0d exp 10", rcvd); end
        checks++; if (m_busy !== 1'b0 || m_ovld !== 1'b0)
            begin errors++; $display("FAIL stall_busy_after got busy=%b valid=%b exp 0 0", m_busy, m_ovld); end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        m_ordy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_valid = 1'b1; m_data = 8'(8'hA0 + i); m_tag = 4'(i); m_check = 8'h00;
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        m_data = 8'h77;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_valid = 1'b0;
        #1;
        checks++; if (m_ovld !== 1'b0 || m_crc !== 8'h00 || m_tago !== 4'h0 || m_match !== 1'b0 || m_busy !== 1'b0)
            begin errors++; $display("FAIL rstmid_outputs got v=%b crc=%h tag=%h m=%b busy=%b exp all 0",
                  m_ovld, m_crc, m_tago, m_match, m_busy); end
        checks++; if (m_irdy !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b exp 1", m_irdy); end
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (m_ovld !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_ghost got %0d valid cycles exp 0", seen); end
    endtask

    logic [7:0] q_crc [16][$];
    logic [3:0] q_tag [16][$];
    logic       q_m   [16][$];

    task automatic sweep_cycle_checks();
        for (int g = 0; g < 16; g++) begin
            checks++; if (s_irdy[g] !== (!s_ovld[g] || s_ordy[g]))
                begin errors++; $display("FAIL sweep_in_ready[%0d] got %b exp %b", g, s_irdy[g], !s_ovld[g] || s_ordy[g]); end
            if (s_ovld[g] === 1'b1) begin
                checks++;
                if (q_crc[g].size() == 0) begin
                    errors++; $display("FAIL sweep_extra[%0d] got crc=%h exp no output", g, s_crc[g]);
                end else if (s_crc[g] !== q_crc[g][0] || s_tago[g] !== q_tag[g][0] || s_match[g] !== q_m[g][0]) begin
                    errors++; $display("FAIL sweep_result[%0d] got crc=%h tag=%h m=%b exp crc=%h tag=%h m=%b",
                        g, s_crc[g], s_tago[g], s_match[g], q_crc[g][0], q_tag[g][0], q_m[g][0]);
                end
                if (s_ordy[g] && q_crc[g].size() != 0) begin
                    void'(q_crc[g].pop_front()); void'(q_tag[g].pop_front()); void'(q_m[g].pop_front());
                end
            end else begin
                checks++; if (s_crc[g] !== 8'h00 || s_tago[g] !== 4'h0 || s_match[g] !== 1'b0)
                    begin errors++; $display("FAIL sweep_gate[%0d] got crc=%h tag=%h m=%b exp 0 0 0", g, s_crc[g], s_tago[g], s_match[g]); end
            end
        end
    endtask

    task automatic test_sweep();
        int first [16];
        int acc   [16];
        int minacc;
        int cyc;
        logic [7:0] d;
        logic [7:0] e;
        s_valid = 1'b0;
        for (int g = 0; g < 16; g++) begin s_ordy[g] = 1'b1; first[g] = 0; acc[g] = 0; end
        repeat (2) @(posedge clk);
        #1;
        d = 8'($urandom);
        s_data = d; s_tag = 4'h9; s_check = 8'h00; s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            #1;
            for (int g = 0; g < 16; g++) begin
                if (s_ovld[g] === 1'b1 && first[g] == 0) begin
                    first[g] = c;
                    checks++; if (s_crc[g] !== sw_ref(d, g))
                        begin errors++; $display("FAIL sweep_first_crc[%0d] got %h exp %h", g, s_crc[g], sw_ref(d, g)); end
                end
            end
            @(posedge clk);
            #1;
        end
        for (int g = 0; g < 16; g++) begin
            checks++; if (first[g] != 8 / sw_b(g))
                begin errors++; $display("FAIL sweep_latency[%0d] got %0d exp %0d", g, first[g], 8 / sw_b(g)); end
        end

        cyc = 0; minacc = 0;
        while (minacc < 1000 && cyc < 4000) begin
            s_valid = ($urandom_range(0, 4) != 0);
            s_data  = 8'($urandom);
            s_tag   = 4'($urandom);
            s_check = ($urandom_range(0, 3) == 0) ? sw_ref(s_data, 0) : 8'($urandom);
            for (int g = 0; g < 16; g++) s_ordy[g] = ($urandom_range(0, 7) != 0);
            #1;
            sweep_cycle_checks();
            for (int g = 0; g < 16; g++) begin
                if (s_valid && s_irdy[g] === 1'b1) begin
                    e = sw_ref(s_data, g);
                    q_crc[g].push_back(e); q_tag[g].push_back(s_tag); q_m[g].push_back(e == s_check);
                    acc[g]++;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            minacc = acc[0];
            for (int g = 1; g < 16; g++) if (acc[g] < minacc) minacc = acc[g];
        end
        checks++; if (minacc < 1000) begin errors++; $display("FAIL sweep_words got %0d exp 1000", minacc); end

        s_valid = 1'b0;
        for (int g = 0; g < 16; g++) s_ordy[g] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            sweep_cycle_checks();
            @(posedge clk);
            #1;
        end
        for (int g = 0; g < 16; g++) begin
            checks++; if (q_crc[g].size() != 0 || s_busy[g] !== 1'b0)
                begin errors++; $display("FAIL sweep_drain[%0d] got left=%0d busy=%b exp 0 0", g, q_crc[g].size(), s_busy[g]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        m_valid = 1'b0; m_data = 8'h00; m_tag = 4'h0; m_check = 8'h00; m_ordy = 1'b1;
        s_valid = 1'b0; s_data = 8'h00; s_tag = 4'h0; s_check = 8'h00;
        for (int g = 0; g < 16; g++) s_ordy[g] = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_init();
        test_stall();
        test_reset_mid();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
